// File: rtl/square_wave_gen.sv
// Square-wave tone generator: a prescaled tick counter toggles the output every
// `note` ticks; a zero note or deasserted enable mutes, a new note restarts cleanly.
module square_wave_gen #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic [7:0] i_note,
    output logic       o_wave,
    output logic       o_active,
    output logic       o_edge
);

    localparam logic [7:0] PRE_LAST = 8'(PRESCALE - 1);

    logic [7:0] r_note;
    logic [7:0] r_pre;
    logic [7:0] r_cnt;
    logic       r_wave;
    logic       r_active;
    logic       r_edge;

    logic       w_mute;
    logic       w_load;
    logic       w_tick;
    logic       w_half_done;

    assign w_mute      = !i_en || (i_note == 8'd0);
    assign w_load      = (i_note != r_note);
    assign w_tick      = (r_pre == PRE_LAST);
    // r_note is at least 1 whenever this is consumed, so the decrement is safe
    assign w_half_done = (r_cnt == (r_note - 8'd1));

    always_ff @(posedge i_clk) begin
        if (i_rst || w_mute) begin
            r_note   <= 8'd0;
            r_pre    <= 8'd0;
            r_cnt    <= 8'd0;
            r_wave   <= 1'b0;
            r_active <= 1'b0;
            r_edge   <= 1'b0;
        end else if (w_load) begin
            // Output level is held across a note change to avoid a glitch
            r_note   <= i_note;
            r_pre    <= 8'd0;
            r_cnt    <= 8'd0;
            r_active <= 1'b1;
            r_edge   <= 1'b0;
        end else begin
            r_pre  <= w_tick ? 8'd0 : r_pre + 8'd1;
            r_edge <= 1'b0;
            if (w_tick) begin
                if (w_half_done) begin
                    r_cnt  <= 8'd0;
                    r_wave <= ~r_wave;
                    r_edge <= 1'b1;
                end else begin
                    r_cnt  <= r_cnt + 8'd1;
                end
            end
        end
    end

    assign o_wave   = r_wave;
    assign o_active = r_active;
    assign o_edge   = r_edge;

endmodule

// File: tb/tb_square_wave_gen.sv
// Directed bench for square_wave_gen: one instance at PRESCALE=4, one at PRESCALE=1.
module tb_square_wave_gen;

    logic       clk = 1'b0;
    logic       rst, en;
    logic [7:0] note;
    logic       wave, active, edge_o;
    logic       b_rst, b_en;
    logic [7:0] b_note;
    logic       b_wave, b_active, b_edge;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    square_wave_gen #(.PRESCALE(4)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_note(note),
        .o_wave(wave), .o_active(active), .o_edge(edge_o)
    );

    square_wave_gen #(.PRESCALE(1)) dut_b (
        .i_clk(clk), .i_rst(b_rst), .i_en(b_en), .i_note(b_note),
        .o_wave(b_wave), .o_active(b_active), .o_edge(b_edge)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs set afterwards apply at the following edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; note = 8'h05;
        b_rst = 1'b1; b_en = 1'b0; b_note = 8'h00;

        // Reset held for two cycles
        step(2);
        chk("rst_wave", wave, 0);
        chk("rst_active", active, 0);
        chk("rst_edge", edge_o, 0);
        rst = 1'b0;
        step(1);
        chk("post_rst_active", active, 1);
        chk("post_rst_wave", wave, 0);

        // Basic period: note 3, P=4 -> toggle every 12 cycles
        note = 8'd3;
        step(1);
        chk("basic_load_active", active, 1);
        for (int i = 1; i <= 36; i++) begin
            step(1);
            chk($sformatf("basic_wave_%0d", i), wave, (i / 12) % 2);
            chk($sformatf("basic_edge_%0d", i), edge_o, (i % 12 == 0) ? 1 : 0);
        end

        // Mute via note=0 for 5 cycles
        note = 8'd0;
        step(1);
        chk("rest_wave", wave, 0);
        chk("rest_active", active, 0);
        chk("rest_edge", edge_o, 0);
        step(4);
        chk("rest_hold_active", active, 0);
        note = 8'd3;
        step(1);
        chk("rest_reload_active", active, 1);
        for (int i = 1; i <= 19; i++) begin
            step(1);
            chk($sformatf("rest_wave_%0d", i), wave, (i >= 12) ? 1 : 0);
        end

        // Note change at L+20 while wave=1
        note = 8'd2;
        step(1);
        chk("chg_hold_wave", wave, 1);
        chk("chg_active", active, 1);
        chk("chg_edge", edge_o, 0);
        for (int j = 1; j <= 24; j++) begin
            step(1);
            chk($sformatf("chg_wave_%0d", j), wave, ((j / 8) % 2 == 0) ? 1 : 0);
            chk($sformatf("chg_edge_%0d", j), edge_o, (j % 8 == 0) ? 1 : 0);
        end

        // Mute via en=0 for 5 cycles (wave is 0 here, so step to a high phase first)
        step(8);
        chk("pre_en_wave", wave, 1);
        en = 1'b0;
        step(1);
        chk("en0_wave", wave, 0);
        chk("en0_active", active, 0);
        step(4);
        en = 1'b1;
        note = 8'd3;
        step(1);
        chk("en_reload_active", active, 1);
        for (int i = 1; i <= 14; i++) begin
            step(1);
            chk($sformatf("en_wave_%0d", i), wave, (i >= 12) ? 1 : 0);
        end

        // Reset pulse at L+15 while wave=1
        rst = 1'b1;
        step(1);
        chk("midrst_wave", wave, 0);
        chk("midrst_active", active, 0);
        chk("midrst_edge", edge_o, 0);
        rst = 1'b0;
        step(1);
        chk("midrst_reload_active", active, 1);
        for (int i = 1; i <= 12; i++) begin
            step(1);
            chk($sformatf("midrst_wave_%0d", i), wave, (i >= 12) ? 1 : 0);
        end

        // Minimum case: P=1, note=1 toggles every cycle
        b_rst = 1'b0; b_en = 1'b1; b_note = 8'd1;
        step(1);
        chk("min_load_active", b_active, 1);
        chk("min_load_wave", b_wave, 0);
        chk("min_load_edge", b_edge, 0);
        for (int i = 1; i <= 6; i++) begin
            step(1);
            chk($sformatf("min_wave_%0d", i), b_wave, i % 2);
            chk($sformatf("min_edge_%0d", i), b_edge, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
